// File: rtl/id_ex_stage_if.sv
// Bundles the decode-side inputs, MEM/WB forward sources, stage controls and EX-side outputs of id_ex_stage.
// The master modport is the pipeline/testbench side; the slave modport is the stage itself.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rd;
  logic [2:0]        id_alusel;
  logic              id_use_pc;
  logic              id_use_imm;
  logic              id_reg_we;
  logic              id_mem_rd;
  logic              id_mem_wr;

  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_we;
  logic [XLEN-1:0]   mem_result;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_we;
  logic [XLEN-1:0]   wb_data;

  logic              hold;
  logic              flush;
  logic              load_stall;

  logic [XLEN-1:0]   ex_operand1;
  logic [XLEN-1:0]   ex_operand2;
  logic [2:0]        ex_alusel;
  logic              ex_nop;
  logic [XLEN-1:0]   ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_we;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic [XLEN-1:0]   ex_pc;
  logic [31:0]       perf_bubbles;
  logic [31:0]       perf_flushes;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_rd, id_alusel, id_use_pc,
           id_use_imm, id_reg_we, id_mem_rd, id_mem_wr,
           mem_rd, mem_reg_we, mem_result, wb_rd, wb_reg_we, wb_data,
           hold, flush,
    input  load_stall, ex_operand1, ex_operand2, ex_alusel, ex_nop,
           ex_store_data, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_pc,
           perf_bubbles, perf_flushes
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_rd, id_alusel, id_use_pc,
           id_use_imm, id_reg_we, id_mem_rd, id_mem_wr,
           mem_rd, mem_reg_we, mem_result, wb_rd, wb_reg_we, wb_data,
           hold, flush,
    output load_stall, ex_operand1, ex_operand2, ex_alusel, ex_nop,
           ex_store_data, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_pc,
           perf_bubbles, perf_flushes
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Optional macro ID_EX_PERF_EN adds bubble/flush performance counters (tied to 0 otherwise).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [2:0]        alusel;
    logic              use_pc;
    logic              use_imm;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
  } ex_slot_t;

  ex_slot_t          ex_q;
  ex_slot_t          cap_d;
  logic              load_stall;
  logic              rs1_hit;
  logic              rs2_hit;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // Handshake: id_valid marks a real instruction in the decode slot. The slot is consumed on
  // every edge where hold=0 and load_stall=0; while load_stall=1 upstream must re-present it.
  // hold freezes this stage entirely, flush kills the decode slot instead of consuming it.
  always_comb begin
    rs1_hit    = bus.id_rs1_used && (bus.id_rs1 == ex_q.rd);
    rs2_hit    = bus.id_rs2_used && (bus.id_rs2 == ex_q.rd);
    load_stall = bus.id_valid && ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) &&
                 (rs1_hit || rs2_hit) && !bus.flush;
  end

  always_comb begin
    cap_d          = '0;
    cap_d.valid    = bus.id_valid;
    cap_d.pc       = bus.id_pc;
    cap_d.rs1      = bus.id_rs1;
    cap_d.rs2      = bus.id_rs2;
    cap_d.rs1_used = bus.id_rs1_used;
    cap_d.rs2_used = bus.id_rs2_used;
    cap_d.rs1_data = bus.id_rs1_data;
    cap_d.rs2_data = bus.id_rs2_data;
    cap_d.imm      = bus.id_imm;
    cap_d.rd       = bus.id_rd;
    cap_d.alusel   = bus.id_alusel;
    cap_d.use_pc   = bus.id_use_pc;
    cap_d.use_imm  = bus.id_use_imm;
    cap_d.reg_we   = bus.id_reg_we && bus.id_valid;
    cap_d.mem_rd   = bus.id_mem_rd && bus.id_valid;
    cap_d.mem_wr   = bus.id_mem_wr && bus.id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (!bus.hold) begin
      if (bus.flush || load_stall) ex_q <= '0;
      else                         ex_q <= cap_d;
    end
  end

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] forward(
    input logic              used,
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   data,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [XLEN-1:0]   m_val,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we,
    input logic [XLEN-1:0]   w_val
  );
    logic [XLEN-1:0] res;
    res = data;
    if (used && (rs != '0)) begin
      if (m_we && (m_rd == rs))      res = m_val;
      else if (w_we && (w_rd == rs)) res = w_val;
    end
    return res;
  endfunction

  always_comb begin
    fwd_rs1 = forward(ex_q.rs1_used, ex_q.rs1, ex_q.rs1_data, bus.mem_rd, bus.mem_reg_we,
                      bus.mem_result, bus.wb_rd, bus.wb_reg_we, bus.wb_data);
    fwd_rs2 = forward(ex_q.rs2_used, ex_q.rs2, ex_q.rs2_data, bus.mem_rd, bus.mem_reg_we,
                      bus.mem_result, bus.wb_rd, bus.wb_reg_we, bus.wb_data);
  end

  assign bus.load_stall    = load_stall;
  assign bus.ex_operand1   = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign bus.ex_operand2   = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_alusel     = ex_q.alusel;
  assign bus.ex_nop        = !ex_q.valid;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_we     = ex_q.reg_we;
  assign bus.ex_mem_rd     = ex_q.mem_rd;
  assign bus.ex_mem_wr     = ex_q.mem_wr;
  assign bus.ex_pc         = ex_q.pc;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else if (!bus.hold) begin
      if (bus.flush)       perf_flushes_q <= perf_flushes_q + 32'd1;
      else if (load_stall) perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign bus.perf_bubbles = perf_bubbles_q;
  assign bus.perf_flushes = perf_flushes_q;
`else
  assign bus.perf_bubbles = '0;
  assign bus.perf_flushes = '0;
`endif

endmodule
